// File: rtl/taylor_pkg.sv
// Shared Q-format defaults, coefficient type and default exp(x) coefficient table for the
// Horner evaluator.
package taylor_pkg;

  localparam int unsigned DEF_WIDTHIN  = 16;
  localparam int unsigned DEF_FRAC_IN  = 14;
  localparam int unsigned DEF_WIDTHOUT = 32;
  localparam int unsigned DEF_FRAC_OUT = 25;
  localparam int unsigned DEF_NTERMS   = 6;

  typedef logic [DEF_WIDTHIN-1:0] coeff_t;

  // a_k of exp(x) in Q2.14, index 5 (1/120) down to index 0 (1)
  localparam coeff_t [DEF_NTERMS-1:0] EXP_COEFFS = {
    16'h0088, 16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000
  };

  // Zero-extended coefficient moved into the accumulator's binary point; caller truncates.
  function automatic logic [63:0] align_coeff(input logic [63:0] coeff, input int unsigned shift);
    return coeff << shift;
  endfunction

endpackage

// File: rtl/horner_stage.sv
// One registered Horner step: acc = MUL(prev_acc, prev_x) + aligned coefficient.
// Saturating arithmetic is selected with the TAYLOR_SAT_EN macro.
module horner_stage
  import taylor_pkg::*;
#(
  parameter int unsigned          WIDTHIN  = DEF_WIDTHIN,
  parameter int unsigned          FRAC_IN  = DEF_FRAC_IN,
  parameter int unsigned          WIDTHOUT = DEF_WIDTHOUT,
  parameter int unsigned          FRAC_OUT = DEF_FRAC_OUT,
  parameter logic [WIDTHIN-1:0]   COEFF    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WIDTHIN-1:0]  prev_x,
  input  logic [WIDTHOUT-1:0] prev_acc,
  input  logic                prev_valid,
  output logic [WIDTHIN-1:0]  x,
  output logic [WIDTHOUT-1:0] acc,
  output logic                valid
);

  localparam int unsigned ProdW = WIDTHOUT + WIDTHIN;
  localparam logic [WIDTHOUT-1:0] CoeffAligned =
      WIDTHOUT'(align_coeff(64'(COEFF), FRAC_OUT - FRAC_IN));

  logic [ProdW-1:0]    prod;
  logic [WIDTHOUT-1:0] mul;
  logic [WIDTHOUT-1:0] acc_d;

  assign prod = ProdW'(prev_acc) * ProdW'(prev_x);

`ifdef TAYLOR_SAT_EN
  logic [WIDTHOUT:0] sum;
  logic              unused_prod_lsbs;

  always_comb begin
    mul = prod[FRAC_IN+WIDTHOUT-1:FRAC_IN];
    if (|prod[ProdW-1:FRAC_IN+WIDTHOUT]) begin
      mul = '1;
    end
    sum   = {1'b0, mul} + {1'b0, CoeffAligned};
    acc_d = sum[WIDTHOUT] ? '1 : sum[WIDTHOUT-1:0];
  end

  assign unused_prod_lsbs = ^prod[FRAC_IN-1:0];
`else
  logic unused_prod_bits;

  always_comb begin
    mul   = prod[FRAC_IN+WIDTHOUT-1:FRAC_IN];
    acc_d = mul + CoeffAligned;
  end

  // Truncation: integer overflow bits and sub-LSB bits are dropped by design
  assign unused_prod_bits = ^{prod[ProdW-1:FRAC_IN+WIDTHOUT], prod[FRAC_IN-1:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x     <= '0;
      acc   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      x     <= prev_x;
      acc   <= acc_d;
      valid <= prev_valid;
    end
  end

endmodule

// File: rtl/taylor_horner_pipe.sv
// Fully pipelined Horner polynomial evaluator, one result per enabled cycle.
// Optional saturating arithmetic: define TAYLOR_SAT_EN.
module taylor_horner_pipe
  import taylor_pkg::*;
#(
  parameter int unsigned                      WIDTHIN  = DEF_WIDTHIN,
  parameter int unsigned                      FRAC_IN  = DEF_FRAC_IN,
  parameter int unsigned                      WIDTHOUT = DEF_WIDTHOUT,
  parameter int unsigned                      FRAC_OUT = DEF_FRAC_OUT,
  parameter int unsigned                      NTERMS   = DEF_NTERMS,
  parameter logic [NTERMS-1:0][WIDTHIN-1:0]   COEFFS   = EXP_COEFFS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                i_ready,
  output logic                o_valid,
  output logic                o_ready,
  input  logic [WIDTHIN-1:0]  i_x,
  output logic [WIDTHOUT-1:0] o_y
);

  localparam logic [WIDTHOUT-1:0] Acc0Init =
      WIDTHOUT'(align_coeff(64'(COEFFS[NTERMS-1]), FRAC_OUT - FRAC_IN));

  logic                en;
  logic [WIDTHIN-1:0]  x0_q;
  logic [WIDTHOUT-1:0] acc0_q;
  logic                v0_q;

  logic [WIDTHIN-1:0]  x_pipe   [NTERMS];
  logic [WIDTHOUT-1:0] acc_pipe [NTERMS];
  logic                v_pipe   [NTERMS];
  logic                unused_last_x;

  // Downstream ready doubles as the pipeline enable: a stall freezes every stage
  assign en      = i_ready;
  assign o_ready = i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q   <= '0;
      acc0_q <= '0;
      v0_q   <= 1'b0;
    end else if (en) begin
      x0_q   <= i_x;
      acc0_q <= Acc0Init;
      v0_q   <= i_valid;
    end
  end

  assign x_pipe[0]   = x0_q;
  assign acc_pipe[0] = acc0_q;
  assign v_pipe[0]   = v0_q;

  for (genvar s = 1; s < NTERMS; s++) begin : g_stage
    horner_stage #(
      .WIDTHIN  (WIDTHIN),
      .FRAC_IN  (FRAC_IN),
      .WIDTHOUT (WIDTHOUT),
      .FRAC_OUT (FRAC_OUT),
      .COEFF    (COEFFS[NTERMS-1-s])
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .prev_x     (x_pipe[s-1]),
      .prev_acc   (acc_pipe[s-1]),
      .prev_valid (v_pipe[s-1]),
      .x          (x_pipe[s]),
      .acc        (acc_pipe[s]),
      .valid      (v_pipe[s])
    );
  end

  assign unused_last_x = ^x_pipe[NTERMS-1];

  assign o_valid = v_pipe[NTERMS-1] & i_ready;
  assign o_y     = acc_pipe[NTERMS-1];

endmodule
